tick_scheduler: RTL

Synchronous clock-enable scheduler that replaces ripple-clock division in the game datapath. A programmable prescaler produces a base tick, and three postscaler channels derive per-consumer ticks and 50 %-duty square waves (display scan, blink, debounce) in the single `clk` domain. A valid/ready configuration port lets the game controller retune the period and divisors at run time. Every change is applied glitch-free on a base-tick boundary.

---
 rtl/tick_scheduler_pkg.sv | 22 ++
 rtl/tick_scheduler_if.sv | 29 ++
 rtl/tick_scheduler_channel.sv | 61 ++++++
 rtl/tick_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: FSM states,
// configuration selector codes and power-on defaults.
package tick_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int NUM_CH = 3;

  localparam logic [1:0] CFG_SEL_PERIOD = 2'd0;
  localparam logic [1:0] CFG_SEL_CH0    = 2'd1;
  localparam logic [1:0] CFG_SEL_CH1    = 2'd2;
  localparam logic [1:0] CFG_SEL_CH2    = 2'd3;

  localparam int PKG_DEF_PERIOD = 50000;
  localparam int PKG_DEF_DIV0   = 1;
  localparam int PKG_DEF_DIV1   = 250;
  localparam int PKG_DEF_DIV2   = 10;

endpackage

// File: rtl/tick_scheduler_if.sv
// Control/config bus of the tick scheduler. The master side is the game
// controller; the slave side is the scheduler itself.
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int PRE_W = 16
) ();

  logic              en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_sel;
  logic [PRE_W-1:0]  cfg_data;
  logic              cfg_err;
  logic              base_tick;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_sq;

  modport master (
    output en, cfg_valid, cfg_sel, cfg_data,
    input  cfg_ready, cfg_err, base_tick, ch_tick, ch_sq
  );

  modport slave (
    input  en, cfg_valid, cfg_sel, cfg_data,
    output cfg_ready, cfg_err, base_tick, ch_tick, ch_sq
  );

endinterface

// File: rtl/tick_scheduler_channel.sv
// One postscaler channel: divides the base tick by a run-time loadable
// divisor and produces a single-cycle tick plus a 50 % square wave.
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CH_W    = 8,
  parameter int DEF_DIV = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            base_tick,
  input  logic            clr,
  input  logic            load,
  input  logic [CH_W-1:0] load_div,
  output logic            ch_tick,
  output logic            ch_sq
);

  logic [CH_W-1:0] div_q, div_d;
  logic [CH_W-1:0] div_cnt_q, div_cnt_d;
  logic            ch_sq_q, ch_sq_d;

  assign ch_tick = base_tick && (div_cnt_q == div_q - CH_W'(1));
  assign ch_sq   = ch_sq_q;

  // Next-state: count base ticks, toggle the square wave on each channel
  // tick; a divisor load restarts the count but leaves the wave phase alone.
  always_comb begin
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    ch_sq_d   = ch_sq_q;
    if (ch_tick) begin
      div_cnt_d = '0;
      ch_sq_d   = ~ch_sq_q;
    end else if (base_tick) begin
      div_cnt_d = div_cnt_q + CH_W'(1);
    end
    if (load) begin
      div_d     = load_div;
      div_cnt_d = '0;
    end
    if (clr) begin
      div_cnt_d = '0;
      ch_sq_d   = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= CH_W'(DEF_DIV);
      div_cnt_q <= '0;
      ch_sq_q   <= 1'b0;
    end else begin
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      ch_sq_q   <= ch_sq_d;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Clock-enable scheduler: run/idle FSM, programmable prescaler producing
// the base tick, three postscaler channels, and a valid/ready config port
// whose accepted values are held pending and applied on a base-tick
// boundary (or immediately when idle) so no tick is ever glitched.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int PRE_W      = 16,
  parameter int CH_W       = 8,
  parameter int DEF_PERIOD = PKG_DEF_PERIOD,
  parameter int DEF_DIV0   = PKG_DEF_DIV0,
  parameter int DEF_DIV1   = PKG_DEF_DIV1,
  parameter int DEF_DIV2   = PKG_DEF_DIV2
) (
  input logic             clk,
  input logic             rst_n,
  tick_scheduler_if.slave bus
);

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0] period_q, period_d;
  logic             pend_vld_q, pend_vld_d;
  logic [1:0]       pend_sel_q, pend_sel_d;
  logic [PRE_W-1:0] pend_data_q, pend_data_d;
  logic             cfg_err_q, cfg_err_d;

  logic              base_tick;
  logic              cfg_accept;
  logic              cfg_ok;
  logic              apply;
  logic              ch_clr;
  logic [NUM_CH-1:0] ch_load;
  logic [NUM_CH-1:0] ch_tick;
  logic [NUM_CH-1:0] ch_sq;

  // Zero is never a legal period or divisor; divisors must fit a channel.
  function automatic logic cfg_is_valid(input logic [1:0]       sel,
                                        input logic [PRE_W-1:0] data);
    logic fits;
    fits = ((data >> CH_W) == '0);
    return (data != '0) && ((sel == CFG_SEL_PERIOD) || fits);
  endfunction

  assign base_tick  = (state_q == ST_RUN) && (pre_cnt_q == period_q - PRE_W'(1));
  assign cfg_accept = bus.cfg_valid && !pend_vld_q;
  assign cfg_ok     = cfg_is_valid(bus.cfg_sel, bus.cfg_data);
  assign apply      = pend_vld_q && ((state_q == ST_IDLE) || base_tick);

  // Run/idle FSM next state follows the enable request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.en)  state_d = ST_RUN;
      ST_RUN:  if (!bus.en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Prescaler, config acceptance/validation and pending-apply bookkeeping.
  always_comb begin
    pre_cnt_d   = '0;
    period_d    = period_q;
    pend_vld_d  = pend_vld_q;
    pend_sel_d  = pend_sel_q;
    pend_data_d = pend_data_q;
    cfg_err_d   = cfg_accept && !cfg_ok;

    // Count only while staying in RUN; the first RUN cycle sees zero.
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !base_tick) begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end

    if (apply) begin
      pend_vld_d = 1'b0;
      if (pend_sel_q == CFG_SEL_PERIOD) period_d = pend_data_q;
    end

    // Accept only when nothing is pending, so this never races apply.
    if (cfg_accept && cfg_ok) begin
      pend_vld_d  = 1'b1;
      pend_sel_d  = bus.cfg_sel;
      pend_data_d = bus.cfg_data;
    end
  end

  // Control registers of the prescaler and config port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q  <= '0;
      period_q   <= PRE_W'(DEF_PERIOD);
      pend_vld_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      period_q   <= period_d;
      pend_vld_q <= pend_vld_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Pending payload; only meaningful while pend_vld_q is set.
  always_ff @(posedge clk) begin
    pend_sel_q  <= pend_sel_d;
    pend_data_q <= pend_data_d;
  end

  assign ch_clr     = (state_d == ST_IDLE);
  assign ch_load[0] = apply && (pend_sel_q == CFG_SEL_CH0);
  assign ch_load[1] = apply && (pend_sel_q == CFG_SEL_CH1);
  assign ch_load[2] = apply && (pend_sel_q == CFG_SEL_CH2);

  tick_channel #(.CH_W(CH_W), .DEF_DIV(DEF_DIV0)) u_ch0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_tick (base_tick),
    .clr       (ch_clr),
    .load      (ch_load[0]),
    .load_div  (pend_data_q[CH_W-1:0]),
    .ch_tick   (ch_tick[0]),
    .ch_sq     (ch_sq[0])
  );

  tick_channel #(.CH_W(CH_W), .DEF_DIV(DEF_DIV1)) u_ch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_tick (base_tick),
    .clr       (ch_clr),
    .load      (ch_load[1]),
    .load_div  (pend_data_q[CH_W-1:0]),
    .ch_tick   (ch_tick[1]),
    .ch_sq     (ch_sq[1])
  );

  tick_channel #(.CH_W(CH_W), .DEF_DIV(DEF_DIV2)) u_ch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .base_tick (base_tick),
    .clr       (ch_clr),
    .load      (ch_load[2]),
    .load_div  (pend_data_q[CH_W-1:0]),
    .ch_tick   (ch_tick[2]),
    .ch_sq     (ch_sq[2])
  );

  assign bus.cfg_ready = !pend_vld_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.base_tick = base_tick;
  assign bus.ch_tick   = ch_tick;
  assign bus.ch_sq     = ch_sq;

endmodule
